regfile_ctx: RTL and testbench

Parametrised general-purpose register file for the RISC datapath: DEPTH×DATA_W array, two combinational read ports, one synchronous write port. The write port supports load, half-word swap and single-bit set/clear/toggle. A shadow bank with a sequencer saves or restores the whole array, one register per cycle, for interrupt/context switches.

---
 rtl/regfile_ctx.sv | 131 +++++++++++++
 tb/tb_regfile_ctx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctx.sv
// regfile_ctx: DEPTH x DATA_W register file, two async read ports, one op-capable write port,
// and a shadow bank with a one-register-per-cycle save/restore sequencer.  Rev 1.0
`default_nettype none

module regfile_ctx #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int BP_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BP_W-1:0]   bit_pos,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              ctx_busy,
  output logic              ctx_done,
  output logic              wr_drop
);

  localparam int                C_DEPTH = 2 ** ADDR_W;
  localparam int                C_HALF  = DATA_W / 2;
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(C_DEPTH - 1);
  localparam logic [31:0]       C_WIDTH = 32'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_RESTORE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   main_q   [C_DEPTH];
  logic [DATA_W-1:0]   main_d   [C_DEPTH];
  logic [DATA_W-1:0]   shadow_q [C_DEPTH];
  logic [DATA_W-1:0]   shadow_d [C_DEPTH];
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   w_cur, w_mask, w_wval;

  // An out-of-range bit index yields an empty mask, turning the bit op into a no-op.
  always_comb begin
    w_cur  = main_q[wr_addr];
    w_mask = '0;
    if (32'(bit_pos) < C_WIDTH) begin
      w_mask = {{(DATA_W-1){1'b0}}, 1'b1} << bit_pos;
    end
    case (wr_op)
      3'b000:  w_wval = wr_data;
      3'b001:  w_wval = {w_cur[C_HALF-1:0], w_cur[DATA_W-1:C_HALF]};
      3'b010:  w_wval = w_cur | w_mask;
      3'b011:  w_wval = w_cur & ~w_mask;
      3'b100:  w_wval = w_cur ^ w_mask;
      default: w_wval = w_cur;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    main_d   = main_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    drop_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          main_d[wr_addr] = w_wval;
        end
        if (save_req) begin
          state_d = S_SAVE;
        end else if (restore_req) begin
          state_d = S_RESTORE;
        end
      end
      S_SAVE, S_RESTORE: begin
        drop_d = wr_en;
        if (state_q == S_SAVE) begin
          shadow_d[idx_q] = main_q[idx_q];
        end else begin
          main_d[idx_q] = shadow_q[idx_q];
        end
        if (idx_q == C_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      for (int i = 0; i < C_DEPTH; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      main_q   <= main_d;
      shadow_q <= shadow_d;
    end
  end

  assign rd_data0 = main_q[rd_addr0];
  assign rd_data1 = main_q[rd_addr1];
  assign ctx_busy = (state_q != S_IDLE);
  assign ctx_done = done_q;
  assign wr_drop  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_ctx.sv
// tb_regfile_ctx: drives a 16x8 and a 32x16 regfile_ctx with shared stimulus; a scoreboard
// compares every cycle's outputs with a timestamp-based reference model.
`default_nettype none

module tb_regfile_ctx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, save_req, restore_req;
  logic [2:0]  wr_op;
  logic [3:0]  wr_addr, rd_addr0, rd_addr1;
  logic [31:0] wr_data;
  logic [4:0]  bit_pos;

  logic [15:0] rd0a, rd1a;
  logic [31:0] rd0b, rd1b;
  logic        busya, donea, dropa, busyb, doneb, dropb;

  always #5 clk = ~clk;

  regfile_ctx #(.DATA_W(16), .ADDR_W(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr[2:0]),
    .wr_data(wr_data[15:0]), .bit_pos(bit_pos[3:0]), .rd_addr0(rd_addr0[2:0]),
    .rd_addr1(rd_addr1[2:0]), .rd_data0(rd0a), .rd_data1(rd1a), .save_req(save_req),
    .restore_req(restore_req), .ctx_busy(busya), .ctx_done(donea), .wr_drop(dropa)
  );

  regfile_ctx #(.DATA_W(32), .ADDR_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
    .wr_data(wr_data), .bit_pos(bit_pos), .rd_addr0(rd_addr0),
    .rd_addr1(rd_addr1), .rd_data0(rd0b), .rd_data1(rd1b), .save_req(save_req),
    .restore_req(restore_req), .ctx_busy(busyb), .ctx_done(doneb), .wr_drop(dropb)
  );

  typedef struct packed {
    logic [31:0] rd0a, rd1a, rd0b, rd1b;
    logic        busya, donea, dropa, busyb, doneb, dropb;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: per instance, the array contents plus the edge at which the
  // current save/restore was accepted; busy/done/copy progress follow from the age.
  int          W[2] = '{16, 32};
  int          D[2] = '{8, 16};
  logic [31:0] mm[2][16];
  logic [31:0] sh[2][16];
  int          kind[2];
  int          start[2];
  logic        mdrop[2];
  int          edge_n = 0;
  int          sweep  = 0;

  function automatic logic [31:0] apply_op(input int w, input logic [31:0] r, input logic [2:0] op,
                                           input logic [31:0] data, input int bp);
    logic [63:0] v, bm, msk;
    int h;
    h   = w / 2;
    msk = (64'd1 << w) - 64'd1;
    v   = {32'd0, r};
    bm  = (bp < w) ? (64'd1 << bp) : 64'd0;
    case (op)
      3'd0: v = {32'd0, data};
      3'd1: v = ((v & ((64'd1 << h) - 64'd1)) << h) | (v >> h);
      3'd2: v = v | bm;
      3'd3: v = v & ~bm;
      3'd4: v = v ^ bm;
      default: ;
    endcase
    return 32'(v & msk);
  endfunction

  function automatic logic m_busy(input int i);
    return kind[i] != 0 && (edge_n - start[i]) <= D[i] - 1;
  endfunction

  function automatic logic m_done(input int i);
    return kind[i] != 0 && (edge_n - start[i]) == D[i];
  endfunction

  function automatic logic [31:0] m_read(input int i, input int j);
    int age;
    age = edge_n - start[i];
    if (kind[i] == 2 && age <= D[i] - 1 && j < age) return sh[i][j];
    return mm[i][j];
  endfunction

  task automatic model_edge(input int i);
    int   a, bp, age_prev;
    logic busy_prev;
    logic [31:0] data;
    if (!rst_n) begin
      for (int j = 0; j < 16; j++) begin
        mm[i][j] = 32'd0;
        sh[i][j] = 32'd0;
      end
      kind[i]  = 0;
      mdrop[i] = 1'b0;
      return;
    end
    age_prev  = edge_n - 1 - start[i];
    busy_prev = kind[i] != 0 && age_prev <= D[i] - 1;
    mdrop[i]  = wr_en && busy_prev;
    if (!busy_prev) begin
      a    = (i == 0) ? int'(wr_addr[2:0]) : int'(wr_addr);
      bp   = (i == 0) ? int'(bit_pos[3:0]) : int'(bit_pos);
      data = (i == 0) ? {16'd0, wr_data[15:0]} : wr_data;
      if (wr_en) mm[i][a] = apply_op(W[i], mm[i][a], wr_op, data, bp);
      if (save_req) begin
        // The shadow only becomes observable through a later restore, so a snapshot suffices.
        for (int j = 0; j < D[i]; j++) sh[i][j] = mm[i][j];
        kind[i]  = 1;
        start[i] = edge_n;
      end else if (restore_req) begin
        kind[i]  = 2;
        start[i] = edge_n;
      end
    end
    if (kind[i] == 2 && (edge_n - start[i]) == D[i]) begin
      for (int j = 0; j < D[i]; j++) mm[i][j] = sh[i][j];
    end
  endtask

  task automatic cycle();
    exp_t e;
    rd_addr0 = 4'(sweep);
    rd_addr1 = 4'($urandom_range(0, 15));
    sweep++;
    @(posedge clk);
    #1;
    edge_n++;
    model_edge(0);
    model_edge(1);
    e.rd0a  = m_read(0, int'(rd_addr0[2:0]));
    e.rd1a  = m_read(0, int'(rd_addr1[2:0]));
    e.rd0b  = m_read(1, int'(rd_addr0));
    e.rd1b  = m_read(1, int'(rd_addr1));
    e.busya = m_busy(0);
    e.donea = m_done(0);
    e.dropa = mdrop[0];
    e.busyb = m_busy(1);
    e.doneb = m_done(1);
    e.dropb = mdrop[1];
    sbq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("rd_data0_16x8", {16'd0, rd0a}, mon_e.rd0a);
      chk("rd_data1_16x8", {16'd0, rd1a}, mon_e.rd1a);
      chk("rd_data0_32x16", rd0b, mon_e.rd0b);
      chk("rd_data1_32x16", rd1b, mon_e.rd1b);
      chk("ctx_busy_16x8", {31'd0, busya}, {31'd0, mon_e.busya});
      chk("ctx_done_16x8", {31'd0, donea}, {31'd0, mon_e.donea});
      chk("wr_drop_16x8", {31'd0, dropa}, {31'd0, mon_e.dropa});
      chk("ctx_busy_32x16", {31'd0, busyb}, {31'd0, mon_e.busyb});
      chk("ctx_done_32x16", {31'd0, doneb}, {31'd0, mon_e.doneb});
      chk("wr_drop_32x16", {31'd0, dropb}, {31'd0, mon_e.dropb});
    end
  end

  task automatic wr(input logic [2:0] op, input int addr, input logic [31:0] data, input int bp);
    wr_en   = 1'b1;
    wr_op   = op;
    wr_addr = 4'(addr);
    wr_data = data;
    bit_pos = 5'(bp);
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic req(input logic s, input logic r);
    save_req    = s;
    restore_req = r;
    cycle();
    save_req    = 1'b0;
    restore_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      kind[i]  = 0;
      start[i] = -100;
      mdrop[i] = 1'b0;
      for (int j = 0; j < 16; j++) begin
        mm[i][j] = 32'd0;
        sh[i][j] = 32'd0;
      end
    end
    rst_n = 1'b0; wr_en = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    wr_op = 3'd0; wr_addr = 4'd0; wr_data = 32'd0; bit_pos = 5'd0;
    rd_addr0 = 4'd0; rd_addr1 = 4'd0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Load then bit/swap/reserved ops on R3.
    wr(3'b000, 3, 32'h0000_A5F0, 0);
    idle(16);
    wr(3'b010, 3, 32'd0, 0);
    wr(3'b011, 3, 32'd0, 15);
    wr(3'b100, 3, 32'd0, 4);
    wr(3'b001, 3, 32'd0, 0);
    wr(3'b111, 3, 32'hDEAD_BEEF, 2);
    idle(16);

    // Save, clobber, restore.
    for (int i = 8; i < 16; i++) wr(3'b000, i, 32'h2000 + 32'(i), 0);
    for (int i = 0; i < 8; i++)  wr(3'b000, i, 32'h1000 + 32'(i), 0);
    req(1'b1, 1'b0);
    idle(18);
    for (int i = 0; i < 16; i++) wr(3'b000, i, 32'h0000_FFFF, 0);
    req(1'b0, 1'b1);
    idle(18);

    // Write during busy is dropped; requests while busy are ignored; save wins a tie.
    req(1'b1, 1'b0);
    idle(2);
    wr(3'b000, 2, 32'h0000_BEEF, 0);
    req(1'b0, 1'b1);
    idle(16);
    wr(3'b000, 2, 32'h0000_1234, 0);
    req(1'b1, 1'b1);
    idle(18);

    // Reset in the middle of a restore.
    req(1'b0, 1'b1);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(20);
    wr(3'b000, 6, 32'h0000_0066, 0);
    req(1'b1, 1'b0);
    idle(18);

    // Wide-word swap and top bit.
    wr(3'b000, 5, 32'h1234_5678, 0);
    wr(3'b001, 5, 32'd0, 0);
    wr(3'b010, 5, 32'd0, 31);
    idle(16);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      wr_en       = 1'($urandom_range(0, 1));
      wr_op       = 3'($urandom_range(0, 7));
      wr_addr     = 4'($urandom_range(0, 15));
      wr_data     = $urandom;
      bit_pos     = 5'($urandom_range(0, 31));
      save_req    = ($urandom_range(0, 29) == 0);
      restore_req = ($urandom_range(0, 29) == 0);
      rst_n       = ($urandom_range(0, 149) != 0);
      cycle();
    end
    wr_en = 1'b0; save_req = 1'b0; restore_req = 1'b0; rst_n = 1'b1;
    idle(20);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
